flash_addr_seq: RTL

- Parametrised successor to the flash address FSM used in the audio playback path.
- Steps a flash read address between programmable START/END bounds, forward or backward, once per sample tick.
- Issues a req/ack read handshake for every address.
- Supports loop or one-shot playback, pause, and restart.
- Sits between the playback control logic (keyboard/command decoder) and the flash read master.

---
 rtl/flash_addr_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/flash_addr_seq.sv
// flash_addr_seq: steps a flash read address between START_ADDR and END_ADDR.
// It moves one step per sample tick, in either direction, and runs a req/ack
// read handshake for every address. Playback can loop or stop at a bound,
// and it supports pause and restart.
// Optional feature: define ADDR_SEQ_SPEED_EN to add the speed[1:0] input.
// The effective step is then STEP << speed.
module flash_addr_seq #(
    parameter int unsigned       ADDR_W     = 23,
    parameter int unsigned       STEP       = 2,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h7FFFE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              restart,
    input  logic              pause,
    input  logic              dir,
    input  logic              loop_en,
    input  logic              tick,
`ifdef ADDR_SEQ_SPEED_EN
    input  logic [1:0]        speed,
`endif
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
);

    // One extra bit so that bound arithmetic can never wrap.
    localparam int unsigned CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_ADV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_d;
    logic              rd_req_d;
    logic              busy_d;
    logic              done_d;

    logic [ADDR_W-1:0] origin;
    logic [CW-1:0]     step_eff;
    logic [CW-1:0]     addr_ext;
    logic [CW-1:0]     fwd_sum;
    logic [CW-1:0]     bwd_floor;
    logic              at_bound;
    logic [ADDR_W-1:0] stepped;
    logic              restart_hit;

    // The effective step, sampled combinationally while in ADV.
`ifdef ADDR_SEQ_SPEED_EN
    assign step_eff = CW'(STEP) << speed;
`else
    assign step_eff = CW'(STEP);
`endif

    // Origin address and boundary detection for the current direction.
    assign origin    = dir ? END_ADDR : START_ADDR;
    assign addr_ext  = {1'b0, addr};
    assign fwd_sum   = addr_ext + step_eff;
    assign bwd_floor = {1'b0, START_ADDR} + step_eff;
    assign at_bound  = dir ? (addr_ext < bwd_floor) : (fwd_sum > {1'b0, END_ADDR});
    assign stepped   = dir ? ADDR_W'(addr_ext - step_eff) : ADDR_W'(fwd_sum);

    // Restart applies in every active state, including DONE, and takes priority there.
    assign restart_hit = restart && ((state_q == S_REQ) || (state_q == S_WAIT) ||
                                     (state_q == S_ADV) || (state_q == S_DONE));

    assign state = state_q;

    // Next-state, next-address and next-output logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr;
        rd_req_d = 1'b0;

        if (restart_hit) begin
            // rd_req stays low for one cycle so the master sees a fresh request.
            state_d = S_REQ;
            addr_d  = origin;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_REQ;
                        addr_d  = origin;
                    end
                end
                S_REQ: begin
                    // An ack is only honoured against a request that is actually raised.
                    if (rd_req && rd_ack) begin
                        state_d = S_WAIT;
                    end else begin
                        rd_req_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (tick && !pause) begin
                        state_d = S_ADV;
                    end
                end
                S_ADV: begin
                    if (!at_bound) begin
                        state_d = S_REQ;
                        addr_d  = stepped;
                    end else if (loop_en) begin
                        // The wrap lands exactly on the opposite bound; any overshoot is dropped.
                        state_d = S_REQ;
                        addr_d  = origin;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs. Reset aborts any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr    <= START_ADDR;
            rd_req  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr    <= addr_d;
            rd_req  <= rd_req_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
